// File: rtl/uart_pkg.sv
// Types and constants for the UART receive/transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

    localparam int UART_CLKS_PER_BIT = 10416;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit. The reset value is chosen by
// the user so that the synchronised signal comes out of reset at its idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: single mid-bit sample per bit, hold-until-ack output,
// framing-error pulse and sticky overrun flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 input_clk,
    input  logic                 reset,
    input  logic                 Rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk  (input_clk),
        .rst_n(reset),
        .d    (Rx),
        .q    (rx_s)
    );

    uart_rx_state_t       state_q,    state_d;
    logic [CW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [IW-1:0]        idx_q,      idx_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 overrun_q,  overrun_d;
    logic                 ferr_q,     ferr_d;

    logic bit_tick;
    logic half_tick;

    assign bit_tick  = (bit_cnt_q == BIT_LAST);
    assign half_tick = (bit_cnt_q == HALF_LAST);

    always_ff @(posedge input_clk) begin
        if (!reset) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        ferr_d     = 1'b0;

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        unique case (state_q)
            RX_IDLE: begin
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                end
            end

            RX_START: begin
                if (half_tick) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            RX_DATA: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            RX_STOP: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    if (rx_s) begin
                        // Newest byte always wins; a same-cycle ack consumes
                        // the old byte, so that case is not an overrun.
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rx_ack) begin
                            overrun_d = 1'b1;
                        end
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_BREAK;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            RX_BREAK: begin
                bit_cnt_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end

            default: begin
                bit_cnt_d = '0;
                state_d   = RX_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != RX_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = overrun_q;

endmodule
